// File: rtl/counter_pkg.sv
// Shared definitions for the up/down modulo counter family: default sizes,
// direction encodings and the load clamp helper.
package counter_pkg;

  localparam int DEF_WIDTH   = 4;
  localparam int DEF_MODULUS = 16;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Out-of-range load values land on the top of the count range.
  function automatic logic [31:0] clamp_load(input logic [31:0] dn, input logic [31:0] modulus);
    return (dn < modulus) ? dn : modulus - 32'd1;
  endfunction

endpackage

// File: rtl/updown_next_val.sv
// Combinational next-count and wrap-detect logic for updown_mod_counter.
// UPDN_COUNTER_SAT_EN selects saturating limits instead of modulo wrap.
module updown_next_val
  import counter_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int MODULUS = DEF_MODULUS
) (
  input  logic [WIDTH-1:0] q,
  input  logic             load,
  input  logic             en,
  input  logic             up,
  input  logic [WIDTH-1:0] dn,
`ifdef UPDN_COUNTER_SAT_EN
  input  logic             sat_hit,
  output logic             sat_hit_next,
`endif
  output logic [WIDTH-1:0] q_next,
  output logic             wrap_next
);

  // One extra bit keeps MODULUS = 2**WIDTH representable without special cases.
  localparam logic [WIDTH:0] MAX_VAL = (WIDTH+1)'(MODULUS - 1);

  logic [WIDTH:0] q_ext;
  logic           at_max;
  logic           at_zero;
  logic           at_limit;

  assign q_ext    = {1'b0, q};
  assign at_max   = (q_ext == MAX_VAL);
  assign at_zero  = (q_ext == '0);
  assign at_limit = (up == DIR_UP) ? at_max : at_zero;

  always_comb begin
    q_next    = q;
    wrap_next = 1'b0;
    if (load) begin
      q_next = WIDTH'(clamp_load(32'(dn), 32'(MODULUS)));
    end else if (en) begin
      if (at_limit) begin
`ifdef UPDN_COUNTER_SAT_EN
        q_next    = q;
        wrap_next = ~sat_hit;
`else
        q_next    = (up == DIR_UP) ? '0 : WIDTH'(MAX_VAL);
        wrap_next = 1'b1;
`endif
      end else if (up == DIR_UP) begin
        q_next = WIDTH'(q_ext + (WIDTH+1)'(1));
      end else begin
        q_next = WIDTH'(q_ext - (WIDTH+1)'(1));
      end
    end
  end

`ifdef UPDN_COUNTER_SAT_EN
  // Remembers that the current stay at a limit has already been reported.
  always_comb begin
    sat_hit_next = sat_hit;
    if (load) begin
      sat_hit_next = 1'b0;
    end else if (en) begin
      sat_hit_next = at_limit;
    end
  end
`endif

endmodule

// File: rtl/updown_mod_counter.sv
// Loadable up/down modulo-N counter with terminal-count flag and registered wrap pulse.
// Define UPDN_COUNTER_SAT_EN to saturate at 0 / MODULUS-1 instead of wrapping.
module updown_mod_counter
  import counter_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int MODULUS = DEF_MODULUS,
  parameter int RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic             up,
  input  logic [WIDTH-1:0] dn,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH:0] MAX_VAL = (WIDTH+1)'(MODULUS - 1);

  logic [WIDTH-1:0] q_next;
  logic             wrap_next;

`ifdef UPDN_COUNTER_SAT_EN
  logic sat_hit;
  logic sat_hit_next;
`endif

  updown_next_val #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_next (
    .q            (q),
    .load         (load),
    .en           (en),
    .up           (up),
    .dn           (dn),
`ifdef UPDN_COUNTER_SAT_EN
    .sat_hit      (sat_hit),
    .sat_hit_next (sat_hit_next),
`endif
    .q_next       (q_next),
    .wrap_next    (wrap_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q    <= WIDTH'(RST_VAL);
      wrap <= 1'b0;
    end else begin
      q    <= q_next;
      wrap <= wrap_next;
    end
  end

`ifdef UPDN_COUNTER_SAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_hit <= 1'b0;
    end else begin
      sat_hit <= sat_hit_next;
    end
  end
`endif

  // Predicts a wrap (or limit hit) on the coming edge.
  assign tc = en & ~load &
              (((up == DIR_UP) & ({1'b0, q} == MAX_VAL)) |
               ((up == DIR_DN) & (q == '0)));

endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed table-driven bench for updown_mod_counter (modulo build, or
// saturating build when UPDN_COUNTER_SAT_EN is defined).
module tb_updown_mod_counter;

  typedef struct {
    logic       load;
    logic       en;
    logic       up;
    logic [3:0] dn;
    logic       exp_tc;
    logic [3:0] exp_q;
    logic       exp_wrap;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // a: WIDTH=4 MODULUS=10 RST_VAL=3
  logic       load_a = 0, en_a = 0, up_a = 0;
  logic [3:0] dn_a = '0, q_a;
  logic       tc_a, wrap_a;
  // b: WIDTH=4 MODULUS=16; c: WIDTH=1 MODULUS=2 (shared controls)
  logic       load_b = 0, en_b = 0, up_b = 0;
  logic [3:0] dn_b = '0, q_b;
  logic       tc_b, wrap_b;
  logic [0:0] q_c;
  logic       tc_c, wrap_c;

  int n_vec = 0;
  int n_err = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  updown_mod_counter #(.WIDTH(4), .MODULUS(10), .RST_VAL(3)) dut_a (
    .clk(clk), .rst(rst), .load(load_a), .en(en_a), .up(up_a), .dn(dn_a),
    .q(q_a), .tc(tc_a), .wrap(wrap_a));

  updown_mod_counter #(.WIDTH(4), .MODULUS(16), .RST_VAL(0)) dut_b (
    .clk(clk), .rst(rst), .load(load_b), .en(en_b), .up(up_b), .dn(dn_b),
    .q(q_b), .tc(tc_b), .wrap(wrap_b));

  updown_mod_counter #(.WIDTH(1), .MODULUS(2), .RST_VAL(0)) dut_c (
    .clk(clk), .rst(rst), .load(load_b), .en(en_b), .up(up_b), .dn(dn_b[0]),
    .q(q_c), .tc(tc_c), .wrap(wrap_c));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic load, input logic en, input logic up, input logic [3:0] dn,
                              input logic tc, input logic [3:0] q, input logic wrap);
    vec_t v;
    v.load = load; v.en = en; v.up = up; v.dn = dn;
    v.exp_tc = tc; v.exp_q = q; v.exp_wrap = wrap;
    return v;
  endfunction

  task automatic drive_b(input logic load, input logic en, input logic up, input logic [3:0] dn);
    @(negedge clk);
    load_b = load; en_b = en; up_b = up; dn_b = dn;
  endtask

  initial begin
    // load  en  up  dn      tc  q      wrap   (dut_a, starts at q=3)
    vecs.push_back(mk(1, 0, 1, 4'd8,  0, 4'd8, 0));
    vecs.push_back(mk(0, 1, 1, 4'd0,  0, 4'd9, 0));
`ifdef UPDN_COUNTER_SAT_EN
    vecs.push_back(mk(0, 1, 1, 4'd0,  1, 4'd9, 1));
    vecs.push_back(mk(0, 1, 1, 4'd0,  1, 4'd9, 0));
    vecs.push_back(mk(0, 1, 0, 4'd0,  0, 4'd8, 0));
    vecs.push_back(mk(1, 1, 0, 4'd0,  0, 4'd0, 0));
    vecs.push_back(mk(0, 1, 0, 4'd0,  1, 4'd0, 1));
    vecs.push_back(mk(0, 1, 0, 4'd0,  1, 4'd0, 0));
    vecs.push_back(mk(0, 0, 0, 4'd0,  0, 4'd0, 0));
`else
    vecs.push_back(mk(0, 1, 1, 4'd0,  1, 4'd0, 1));
    vecs.push_back(mk(0, 1, 1, 4'd0,  0, 4'd1, 0));
    vecs.push_back(mk(1, 1, 0, 4'd0,  0, 4'd0, 0));
    vecs.push_back(mk(0, 1, 0, 4'd0,  1, 4'd9, 1));
    vecs.push_back(mk(0, 0, 0, 4'd0,  0, 4'd9, 0));
    vecs.push_back(mk(0, 0, 1, 4'd0,  0, 4'd9, 0));
    vecs.push_back(mk(1, 0, 0, 4'd15, 0, 4'd9, 0));
    vecs.push_back(mk(0, 1, 1, 4'd0,  1, 4'd0, 1));
    vecs.push_back(mk(0, 1, 0, 4'd0,  1, 4'd9, 1));
    vecs.push_back(mk(0, 0, 0, 4'd0,  0, 4'd9, 0));
`endif
    vecs.push_back(mk(1, 1, 1, 4'd13, 0, 4'd9, 0));
    vecs.push_back(mk(1, 1, 1, 4'd5,  0, 4'd5, 0));
    vecs.push_back(mk(0, 1, 0, 4'd0,  0, 4'd4, 0));
    vecs.push_back(mk(0, 1, 1, 4'd0,  0, 4'd5, 0));

    // Reset asserted from time 0, with clock running.
    repeat (2) @(posedge clk);
    #1;
    check("reset q_a", q_a, 3);
    check("reset wrap_a", wrap_a, 0);
    check("reset q_b", q_b, 0);
    check("reset q_c", q_c, 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      load_a = vecs[i].load; en_a = vecs[i].en; up_a = vecs[i].up; dn_a = vecs[i].dn;
      #1;
      check($sformatf("vec%0d tc", i), tc_a, vecs[i].exp_tc);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d q", i), q_a, vecs[i].exp_q);
      check($sformatf("vec%0d wrap", i), wrap_a, vecs[i].exp_wrap);
    end

    // Mid-cycle reset clears q and a pending wrap with no clock edge.
    @(negedge clk);
    load_a = 1; en_a = 0; up_a = 1; dn_a = 4'd9;
    @(negedge clk);
    load_a = 0; en_a = 1;
    @(posedge clk);
    #1;
    check("pre-reset wrap", wrap_a, 1);
`ifdef UPDN_COUNTER_SAT_EN
    check("pre-reset q", q_a, 9);
`else
    check("pre-reset q", q_a, 0);
`endif
    #2;
    rst = 1'b1;
    #1;
    check("async reset q", q_a, 3);
    check("async reset wrap", wrap_a, 0);
    @(negedge clk);
    rst = 1'b0; en_a = 0;
    @(posedge clk);
    #1;
    check("post-reset hold q", q_a, 3);

    // Full range on b (MODULUS=2**WIDTH) and alternating direction on c (MODULUS=2).
    drive_b(1, 0, 1, 4'd15);
    @(posedge clk); #1;
    check("b load 15", q_b, 15);
    check("c load 1", q_c, 1);
    drive_b(0, 1, 1, 4'd0);
    #1;
    check("b tc at 15", tc_b, 1);
    check("c tc at 1 up", tc_c, 1);
    @(posedge clk); #1;
`ifdef UPDN_COUNTER_SAT_EN
    check("b sat q", q_b, 15);
    check("b sat wrap", wrap_b, 1);
    check("c sat q", q_c, 1);
    check("c sat wrap", wrap_c, 1);
    drive_b(0, 1, 0, 4'd0);
    @(posedge clk); #1;
    check("b down q", q_b, 14);
    check("b down wrap", wrap_b, 0);
    check("c down q", q_c, 0);
    check("c down wrap", wrap_c, 0);
    drive_b(0, 1, 0, 4'd0);
    @(posedge clk); #1;
    check("c sat low q", q_c, 0);
    check("c sat low wrap", wrap_c, 1);
`else
    check("b wrap q", q_b, 0);
    check("b wrap pulse", wrap_b, 1);
    check("c wrap q 1", q_c, 0);
    check("c wrap 1", wrap_c, 1);
    drive_b(0, 1, 0, 4'd0);
    @(posedge clk); #1;
    check("b down-wrap q", q_b, 15);
    check("b down-wrap pulse", wrap_b, 1);
    check("c wrap q 2", q_c, 1);
    check("c wrap 2", wrap_c, 1);
    drive_b(0, 1, 1, 4'd0);
    @(posedge clk); #1;
    check("b wrap again q", q_b, 0);
    check("c wrap q 3", q_c, 0);
    check("c wrap 3", wrap_c, 1);
    drive_b(0, 1, 1, 4'd0);
    @(posedge clk); #1;
    check("b count q", q_b, 1);
    check("b wrap low", wrap_b, 0);
    check("c count q", q_c, 1);
    check("c wrap low", wrap_c, 0);
`endif
    drive_b(0, 0, 1, 4'd0);
    @(posedge clk); #1;
    check("c idle wrap", wrap_c, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
